puf_measure_ctrl: RTL and testbench
===================================

# puf_measure_ctrl

Measurement sequencer for the multi-bit ring-oscillator PUF. It runs one measurement per response bit:
- selects a ring-oscillator pair from the latched challenge;
- clears the pair's 4-bit edge counters;
- enables the oscillators for a fixed window, then lets them stop and the counts settle;
- samples both counts and compares them to produce that response bit.

After N_BITS measurements it presents the assembled response with a one-cycle done pulse. It sits between the system-clock host logic and the oscillator/counter datapath.

## Interface
Parameters:
- N_BITS, 8, response bits per challenge (1..32)
- SEL_W, 3, width of one oscillator-pair select field
- WINDOW, 12, system-clock cycles ro_en is held high per bit (>=1)
- SETTLE, 4, cycles after ro_en falls before sampling (>=2)
- CNT_W, 4, counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a measurement sequence
- challenge  in  N_BITS*SEL_W  pair selects; field i = challenge[i*SEL_W +: SEL_W]
- count0  in  CNT_W  oscillator-0 edge count from the counter pair
- count1  in  CNT_W  oscillator-1 edge count from the counter pair
- ro_sel  out  SEL_W  oscillator-pair select for the current bit
- ro_en  out  1  oscillator enable
- cnt_reset  out  1  counter clear, active-high
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse, response valid
- response  out  N_BITS  bit i = 1 when count0 > count1 for measurement i
- tie_mask  out  N_BITS  bit i = 1 when count0 == count1 for measurement i

## Operation
- Reset values:
  - ro_en=0, cnt_reset=1, busy=0, done=0;
  - response=0, tie_mask=0, ro_sel=0;
  - state IDLE, bit index 0.
- Reset is asynchronous at any time, including mid-sequence, and returns the block to these values immediately.
- IDLE: cnt_reset=1, ro_en=0, busy=0.
  - start=1 latches challenge, clears response, tie_mask and the bit index, and enters CLR.
  - start is ignored in every other state.
- CLR (2 cycles): ro_sel = field[bit index]; cnt_reset=1; ro_en=0. Then RUN.
- RUN (WINDOW cycles): cnt_reset=0; ro_en=1. Then SETTLE.
- SETTLE (SETTLE cycles): ro_en=0; cnt_reset=0. Counters are frozen by the end of this state. Then SAMPLE.
- SAMPLE (1 cycle): count0 and count1 are registered into internal capture registers. Then DECIDE.
- DECIDE (1 cycle), using the captured counts:
  - response[bit index] = (cap0 > cap1), unsigned compare;
  - tie_mask[bit index] = (cap0 == cap1);
  - if bit index == N_BITS-1, enter DONE; otherwise increment the bit index and enter CLR.
- DONE (1 cycle): done=1, cnt_reset=1, busy=0. Then IDLE.
- busy=1 in CLR, RUN, SETTLE, SAMPLE and DECIDE.
- ro_sel holds its value from CLR through DECIDE of each bit. It keeps the last field after DONE.
- Counter wrap (15 -> 0) is not detected. WINDOW is chosen by integration so that counts stay below 2^CNT_W; a wrapped count is compared as-is.
- response and tie_mask update only in DECIDE. They are stable from done until the next accepted start.

## Timing
- Start is accepted on the clk edge where start=1 in IDLE. The first CLR cycle follows.
- Per-bit duration P = WINDOW + SETTLE + 4 cycles: CLR 2, RUN WINDOW, SETTLE SETTLE, SAMPLE 1, DECIDE 1.
- done is asserted exactly N_BITS*P cycles after the start-accept cycle. The block is back in IDLE the following cycle.
- A start asserted in the same cycle as done is ignored. A start in the first IDLE cycle after done is accepted.
- All outputs are registered and change only on clk edges or reset assertion.
- count0 and count1 are asynchronous to clk but static during SAMPLE (guaranteed by SETTLE >= 2). They are captured with a single register; no handshake is needed.

## Test plan
All scenarios use N_BITS=4, SEL_W=3, WINDOW=8, SETTLE=2, so P=14.
- Reset and idle:
  - assert reset mid-cycle -> outputs take reset values asynchronously (cnt_reset=1, others 0);
  - with reset released and start=0 -> nothing changes for 50 cycles.
- Full sequence:
  - challenge=12'o7531, start pulse; model drives count0/count1 = (9,4), (3,11), (6,6), (15,0) for bits 0..3;
  - -> ro_sel = 1, 3, 5, 7 in order; done exactly 56 cycles after accept;
  - response=4'b1001, tie_mask=4'b0100;
  - ro_en high for exactly 8 cycles per bit, cnt_reset high for exactly 2 cycles before each RUN.
- Start while busy:
  - extra start pulses at cycles 5 and 30 of a sequence -> ignored; done still at cycle 56;
  - challenge changed mid-sequence -> no effect on ro_sel.
- Reset mid-operation:
  - reset asserted during RUN of bit 2 -> ro_en=0 and cnt_reset=1 immediately, response=0, done never pulses;
  - a new start after release -> full sequence with bit index restarting at 0.
- Back-to-back:
  - start in the done cycle -> ignored;
  - start in the following cycle -> accepted, with response cleared to 0 on accept.
- Wrap value:
  - counts (0,15) -> response bit 0, tie 0 (no wrap compensation).

Source files
------------

// File: rtl/puf_measure_ctrl.sv
// rtl/puf_measure_ctrl.sv - ring-oscillator PUF measurement sequencer
module puf_measure_ctrl #(
    parameter int N_BITS = 8,
    parameter int SEL_W  = 3,
    parameter int WINDOW = 12,
    parameter int SETTLE = 4,
    parameter int CNT_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N_BITS*SEL_W-1:0]   challenge,
    input  logic [CNT_W-1:0]          count0,
    input  logic [CNT_W-1:0]          count1,
    output logic [SEL_W-1:0]          ro_sel,
    output logic                      ro_en,
    output logic                      cnt_reset,
    output logic                      busy,
    output logic                      done,
    output logic [N_BITS-1:0]         response,
    output logic [N_BITS-1:0]         tie_mask
);

    localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int TMR_W = $clog2(WINDOW + SETTLE + 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLR    = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_SAMPLE = 3'd4;
    localparam logic [2:0] S_DECIDE = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]              state_q, state_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [N_BITS*SEL_W-1:0] chal_q, chal_d;
    logic [CNT_W-1:0]        cap0_q, cap0_d, cap1_q, cap1_d;
    logic [N_BITS-1:0]       resp_q, resp_d, tie_q, tie_d;
    logic [SEL_W-1:0]        ro_sel_q, ro_sel_d;
    logic                    ro_en_q, ro_en_d;
    logic                    cnt_reset_q, cnt_reset_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        chal_d  = chal_q;
        cap0_d  = cap0_q;
        cap1_d  = cap1_q;
        resp_d  = resp_q;
        tie_d   = tie_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    chal_d  = challenge;
                    resp_d  = '0;
                    tie_d   = '0;
                    idx_d   = '0;
                    tmr_d   = '0;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                if (tmr_q == TMR_W'(1)) begin
                    tmr_d   = '0;
                    state_d = S_RUN;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_RUN: begin
                if (tmr_q == TMR_W'(WINDOW - 1)) begin
                    tmr_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (tmr_q == TMR_W'(SETTLE - 1)) begin
                    tmr_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                cap0_d  = count0;
                cap1_d  = count1;
                state_d = S_DECIDE;
            end
            S_DECIDE: begin
                resp_d[idx_q] = (cap0_q > cap1_q);
                tie_d[idx_q]  = (cap0_q == cap1_q);
                if (idx_q == IDX_W'(N_BITS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_CLR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        ro_sel_d = ro_sel_q;
        if (state_d == S_CLR) begin
            for (int i = 0; i < N_BITS; i++) begin
                if (idx_d == i[IDX_W-1:0]) begin
                    ro_sel_d = chal_d[i*SEL_W +: SEL_W];
                end
            end
        end
        ro_en_d     = (state_d == S_RUN);
        cnt_reset_d = (state_d == S_IDLE) || (state_d == S_CLR) || (state_d == S_DONE);
        busy_d      = (state_d == S_CLR) || (state_d == S_RUN) || (state_d == S_SETTLE) ||
                      (state_d == S_SAMPLE) || (state_d == S_DECIDE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            idx_q       <= '0;
            chal_q      <= '0;
            cap0_q      <= '0;
            cap1_q      <= '0;
            resp_q      <= '0;
            tie_q       <= '0;
            ro_sel_q    <= '0;
            ro_en_q     <= 1'b0;
            cnt_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            idx_q       <= idx_d;
            chal_q      <= chal_d;
            cap0_q      <= cap0_d;
            cap1_q      <= cap1_d;
            resp_q      <= resp_d;
            tie_q       <= tie_d;
            ro_sel_q    <= ro_sel_d;
            ro_en_q     <= ro_en_d;
            cnt_reset_q <= cnt_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ro_sel    = ro_sel_q;
    assign ro_en     = ro_en_q;
    assign cnt_reset = cnt_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign response  = resp_q;
    assign tie_mask  = tie_q;

endmodule

// File: tb/tb_puf_measure_ctrl.sv
// tb/tb_puf_measure_ctrl.sv - directed self-checking bench for puf_measure_ctrl
module tb_puf_measure_ctrl;

    localparam int NB = 4;
    localparam int SW = 3;
    localparam int P  = 14;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [11:0]   challenge = '0;
    logic [3:0]    count0, count1;
    logic [2:0]    ro_sel;
    logic          ro_en, cnt_reset, busy, done;
    logic [3:0]    response, tie_mask;

    logic [3:0]    t0 [8];
    logic [3:0]    t1 [8];

    int chk = 0;
    int err = 0;

    puf_measure_ctrl #(
        .N_BITS(NB), .SEL_W(SW), .WINDOW(8), .SETTLE(2), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .challenge(challenge),
        .count0(count0), .count1(count1), .ro_sel(ro_sel), .ro_en(ro_en),
        .cnt_reset(cnt_reset), .busy(busy), .done(done),
        .response(response), .tie_mask(tie_mask)
    );

    always #5 clk = ~clk;

    // Counter-pair model: counts depend on which oscillator pair is selected.
    assign count0 = t0[ro_sel];
    assign count1 = t1[ro_sel];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered 1 time unit after the accept edge; leaves in the done cycle.
    task automatic run_body(input string nm, input logic [11:0] exp_sel,
                            input logic [3:0] exp_resp, input logic [3:0] exp_tie,
                            input bit inject);
        int en_ok = 0, en_all = 0, cr_ok = 0, cr_all = 0, busy_n = 0, done_n = 0;
        logic [11:0] sel_seen = '0;
        for (int cyc = 1; cyc <= NB * P; cyc++) begin
            int o;
            int b;
            o = (cyc - 1) % P;
            b = (cyc - 1) / P;
            if (o == 0) sel_seen[b*3 +: 3] = ro_sel;
            if (ro_en) begin
                en_all++;
                if (o >= 2 && o <= 9) en_ok++;
            end
            if (cnt_reset) begin
                cr_all++;
                if (o <= 1) cr_ok++;
            end
            if (busy) busy_n++;
            if (done) done_n++;
            if (inject && (cyc == 5 || cyc == 30)) begin
                start = 1'b1;
                challenge = 12'o0000;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        check({nm, "_sel_order"}, 32'(sel_seen), 32'(exp_sel));
        check({nm, "_ro_en_total"}, en_all, 32);
        check({nm, "_ro_en_in_run"}, en_ok, 32);
        check({nm, "_cnt_reset_total"}, cr_all, 8);
        check({nm, "_cnt_reset_pre_run"}, cr_ok, 8);
        check({nm, "_busy_cycles"}, busy_n, 56);
        check({nm, "_done_early"}, done_n, 0);
        check({nm, "_done_at_56"}, 32'(done), 1);
        check({nm, "_busy_in_done"}, 32'(busy), 0);
        check({nm, "_response"}, 32'(response), 32'(exp_resp));
        check({nm, "_tie_mask"}, 32'(tie_mask), 32'(exp_tie));
    endtask

    task automatic accept(input logic [11:0] ch);
        challenge = ch;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int changes;
        int dn;
        // sel: 1:(9,4) 3:(3,11) 5:(6,6) 7:(15,0) 6:(0,15) 4:(15,14) 2:(7,7) 0:(1,0)
        t0[1] = 4'd9;  t1[1] = 4'd4;
        t0[3] = 4'd3;  t1[3] = 4'd11;
        t0[5] = 4'd6;  t1[5] = 4'd6;
        t0[7] = 4'd15; t1[7] = 4'd0;
        t0[6] = 4'd0;  t1[6] = 4'd15;
        t0[4] = 4'd15; t1[4] = 4'd14;
        t0[2] = 4'd7;  t1[2] = 4'd7;
        t0[0] = 4'd1;  t1[0] = 4'd0;

        #2 reset = 1'b1;
        #1;
        check("rst_ro_en", 32'(ro_en), 0);
        check("rst_cnt_reset", 32'(cnt_reset), 1);
        check("rst_busy_done", {30'd0, busy, done}, 0);
        check("rst_resp_tie_sel", {21'd0, response, tie_mask, ro_sel}, 0);
        #19 reset = 1'b0;

        changes = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if ({ro_en, cnt_reset, busy, done, response, tie_mask, ro_sel} !== {4'b0100, 11'd0})
                changes++;
        end
        check("idle_50_stable", changes, 0);

        // Full sequence
        step();
        accept(12'o7531);
        run_body("full", {3'd7, 3'd5, 3'd3, 3'd1}, 4'b1001, 4'b0100, 1'b0);
        step();
        check("full_idle_after", {30'd0, busy, done}, 0);

        // Start while busy plus challenge change
        step();
        accept(12'o7531);
        run_body("busy_ign", {3'd7, 3'd5, 3'd3, 3'd1}, 4'b1001, 4'b0100, 1'b1);
        step();

        // Reset mid-operation during RUN of bit 2
        step();
        accept(12'o7531);
        for (int i = 0; i < 2 * P + 2; i++) step();
        check("mid_pre_ro_en", 32'(ro_en), 1);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_ro_en_cr", {30'd0, ro_en, cnt_reset}, 1);
        check("mid_rst_resp_busy", {27'd0, response, busy}, 0);
        step();
        #3 reset = 1'b0;
        dn = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (done) dn++;
        end
        check("mid_no_done", dn, 0);
        accept(12'o7531);
        run_body("restart", {3'd7, 3'd5, 3'd3, 3'd1}, 4'b1001, 4'b0100, 1'b0);

        // Back-to-back: start in done cycle ignored, next cycle accepted
        challenge = 12'o0246;
        start = 1'b1;
        step();
        check("b2b_done_ign", {30'd0, busy, done}, 0);
        check("b2b_resp_held", 32'(response), 32'(4'b1001));
        step();
        start = 1'b0;
        check("b2b_accept_busy", 32'(busy), 1);
        check("b2b_resp_clr", {24'd0, response, tie_mask}, 0);
        // Wrap value (0,15) on bit 0 compared as-is
        run_body("wrap", {3'd0, 3'd2, 3'd4, 3'd6}, 4'b1010, 4'b0100, 1'b0);

        step();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
